// File: rtl/spi_arb_pkg.sv
// Shared types for the round-robin SPI master arbiter.
// FSM state encoding and per-transfer SPI mode bundle.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI bit engine: sclk edge timing, MSB-first mosi shifting, miso capture.
// Tick k=1..2*DATA_W toggles sclk; tick 2*DATA_W+1 ends the hold phase.
module spi_shift_engine
    import spi_arb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  spi_mode_t         i_mode,
    input  logic [DATA_W-1:0] i_tx,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic [DATA_W-1:0] o_rx,
    output logic              o_tick,
    output logic              o_last_toggle,
    output logic              o_finished
);

    localparam int EW = $clog2(2*DATA_W+1);
    localparam int HW = $clog2(HALF_PERIOD+1);
    localparam logic [HW-1:0] H_RELOAD = HW'(HALF_PERIOD-1);
    localparam logic [EW-1:0] E_LAST   = EW'(2*DATA_W);
    localparam logic [EW-1:0] E_PRE    = EW'(2*DATA_W-1);

    logic              r_active;
    spi_mode_t         r_mode;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_rx;
    logic              r_sclk;
    logic              r_mosi;
    logic [HW-1:0]     r_hcnt;
    logic [EW-1:0]     r_ecnt;

    logic              w_tick;
    logic              w_lead;
    logic              w_sample;
    logic [DATA_W-1:0] w_shl;
    logic [DATA_W:0]   w_rx_next;

    always_comb begin
        w_tick    = r_active && (r_hcnt == '0);
        w_lead    = ~r_ecnt[0];
        w_sample  = w_lead ^ r_mode.cpha;
        w_shl     = r_shreg << 1;
        w_rx_next = {r_rx, i_miso};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_mode   <= '0;
            r_shreg  <= '0;
            r_rx     <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_hcnt   <= '0;
            r_ecnt   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_mode   <= i_mode;
            r_shreg  <= i_tx;
            r_sclk   <= i_mode.cpol;
            r_mosi   <= i_mode.cpha ? 1'b0 : i_tx[DATA_W-1];
            r_hcnt   <= H_RELOAD;
            r_ecnt   <= '0;
        end else if (w_tick) begin
            r_hcnt <= H_RELOAD;
            r_ecnt <= r_ecnt + 1'b1;
            if (r_ecnt == E_LAST) begin
                r_active <= 1'b0;
                r_mosi   <= 1'b0;
            end else begin
                r_sclk <= ~r_sclk;
                if (w_sample) begin
                    r_rx <= w_rx_next[DATA_W-1:0];
                end else if (r_ecnt != E_PRE) begin
                    // cpha=1 presents the current MSB; cpha=0 already shows it
                    r_mosi  <= r_mode.cpha ? r_shreg[DATA_W-1] : w_shl[DATA_W-1];
                    r_shreg <= w_shl;
                end
            end
        end else if (r_active) begin
            r_hcnt <= r_hcnt - 1'b1;
        end
    end

    assign o_sclk        = r_sclk;
    assign o_mosi        = r_mosi;
    assign o_rx          = r_rx;
    assign o_tick        = w_tick;
    assign o_last_toggle = w_tick && (r_ecnt == E_PRE);
    assign o_finished    = w_tick && (r_ecnt == E_LAST);

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master bus among NUM_REQ clients.
// Latches the winner's word and mode at gnt and owns cs_n/done sequencing.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_tx_data,
    input  logic [NUM_REQ-1:0]        req_cpol,
    input  logic [NUM_REQ-1:0]        req_cpha,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic [NUM_REQ-1:0]        cs_n
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW-1:0] P_MAX = PW'(NUM_REQ-1);

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_win;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_cs_n;
    logic [DATA_W-1:0] r_rx;
    logic              r_busy;

    logic              w_any;
    logic              w_found;
    int                w_idx;
    logic [PW-1:0]     w_win;
    logic [NUM_REQ-1:0] w_win_oh;
    logic              w_start;
    spi_mode_t         w_mode;
    logic [DATA_W-1:0] w_tx;
    logic [DATA_W-1:0] w_rx;
    logic              w_tick;
    logic              w_last_toggle;
    logic              w_finished;

    // First set request at or above r_ptr, wrapping around
    always_comb begin
        w_any   = |req;
        w_found = 1'b0;
        w_idx   = 0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
        w_win_oh    = NUM_REQ'(1) << w_win;
        w_start     = (r_state == IDLE) && w_any;
        w_mode.cpol = req_cpol[w_win];
        w_mode.cpha = req_cpha[w_win];
        w_tx        = req_tx_data[w_win*DATA_W +: DATA_W];
    end

    spi_shift_engine #(
        .DATA_W      (DATA_W),
        .HALF_PERIOD (HALF_PERIOD)
    ) u_engine (
        .clk           (clk),
        .rst           (rst),
        .i_start       (w_start),
        .i_mode        (w_mode),
        .i_tx          (w_tx),
        .i_miso        (miso),
        .o_sclk        (sclk),
        .o_mosi        (mosi),
        .o_rx          (w_rx),
        .o_tick        (w_tick),
        .o_last_toggle (w_last_toggle),
        .o_finished    (w_finished)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_cs_n  <= '1;
            r_rx    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win_oh;
                        r_win   <= w_win;
                        r_cs_n  <= ~w_win_oh;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_last_toggle) r_state <= HOLD;
                end
                HOLD: begin
                    if (w_finished) begin
                        r_done  <= NUM_REQ'(1) << r_win;
                        r_rx    <= w_rx;
                        r_busy  <= 1'b0;
                        r_cs_n  <= '1;
                        r_ptr   <= (r_win == P_MAX) ? '0 : r_win + 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign cs_n    = r_cs_n;
    assign rx_data = r_rx;
    assign busy    = r_busy;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter (scoreboard of expected done/rx).
// Covers modes 0 and 3, round-robin order, fairness, async reset, withdrawal.
module tb_spi_master_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int HP = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] txd = '0;
    logic [N-1:0] cpol = '0;
    logic [N-1:0] cpha = '0;
    logic         miso;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic [W-1:0] rx_data;
    logic         busy;
    logic         sclk;
    logic         mosi;
    logic [N-1:0] cs_n;

    spi_master_arbiter #(
        .NUM_REQ     (N),
        .DATA_W      (W),
        .HALF_PERIOD (HP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_tx_data (txd),
        .req_cpol    (cpol),
        .req_cpha    (cpha),
        .gnt         (gnt),
        .done        (done),
        .rx_data     (rx_data),
        .busy        (busy),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .cs_n        (cs_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] rx;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // miso source: loopback of mosi, or a mode-3 slave shifting on falling sclk
    logic       loop = 1'b1;
    logic       slv_en = 1'b0;
    logic [7:0] slv_word = 8'h00;
    int         slv_cnt = 0;
    logic       slv_bit;

    always @(negedge sclk) if (slv_en) slv_cnt <= slv_cnt + 1;

    always_comb begin
        slv_bit = 1'b0;
        if (slv_en && slv_cnt >= 1 && slv_cnt <= 8) slv_bit = slv_word[8-slv_cnt];
    end

    assign miso = loop ? mosi : slv_bit;

    logic       cap_en = 1'b0;
    logic [7:0] mosi_cap = 8'h00;
    always @(posedge sclk) if (cap_en) mosi_cap <= {mosi_cap[6:0], mosi};

    int gnt_bad = 0;
    int cs_bad = 0;
    int gnt2_cnt = 0;
    int cs2_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(gnt)) gnt_bad <= gnt_bad + 1;
            if (!$onehot0(~cs_n)) cs_bad <= cs_bad + 1;
            if (gnt[2]) gnt2_cnt <= gnt2_cnt + 1;
            if (!cs_n[2]) cs2_cnt <= cs2_cnt + 1;
        end
    end

    task automatic wait_gnt(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (gnt !== '0 || done !== '0) begin
            fails++;
            $display("FAIL reset_pulses gnt=%b done=%b, required 0", gnt, done);
        end
        tests++;
        if (busy !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b0) begin
            fails++;
            $display("FAIL reset_bus busy=%b sclk=%b mosi=%b, required 0", busy, sclk, mosi);
        end
        tests++;
        if (cs_n !== 4'hF || rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_cs cs_n=%b rx=%h, required 1111/00", cs_n, rx_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0;
        bit   ok;
        int   t0;
        int   toggles;
        logic prev;
        exp_t e;
        loop = 1'b1;
        cpol = '0;
        cpha = '0;
        txd[7:0] = 8'hA3;
        req = 4'b0001;
        wait_gnt(10, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL m0_gnt_timeout gnt=%b, required 0001", gnt);
        end
        t0 = cyc;
        tests++;
        if (gnt !== 4'b0001 || cs_n !== 4'b1110) begin
            fails++;
            $display("FAIL m0_grant gnt=%b cs_n=%b, required 0001/1110", gnt, cs_n);
        end
        tests++;
        if (sclk !== 1'b0 || busy !== 1'b1 || mosi !== 1'b1) begin
            fails++;
            $display("FAIL m0_setup sclk=%b busy=%b mosi=%b, required 0/1/1", sclk, busy, mosi);
        end
        sb.push_back('{idx: 0, rx: 8'hA3});
        req = '0;
        txd[7:0] = 8'hFF;
        toggles = 0;
        prev = sclk;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sclk !== prev) toggles++;
            prev = sclk;
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || cyc - t0 != 34) begin
            fails++;
            $display("FAIL m0_latency got %0d cycles, required 34", cyc - t0);
        end
        tests++;
        if (toggles != 16) begin
            fails++;
            $display("FAIL m0_toggles got %0d, required 16", toggles);
        end
        e = sb.pop_front();
        tests++;
        if (done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
            fails++;
            $display("FAIL m0_rx done=%b rx=%h, required %b/%h", done, rx_data, 4'b0001 << e.idx, e.rx);
        end
        tests++;
        if (cs_n !== 4'hF || busy !== 1'b0 || mosi !== 1'b0) begin
            fails++;
            $display("FAIL m0_end cs_n=%b busy=%b mosi=%b, required 1111/0/0", cs_n, busy, mosi);
        end
    endtask

    task automatic test_mode3;
        bit   ok;
        int   bad;
        exp_t e;
        loop = 1'b0;
        cpol[2] = 1'b1;
        cpha[2] = 1'b1;
        txd[23:16] = 8'h5C;
        slv_word = 8'h96;
        @(negedge clk);
        req = 4'b0100;
        wait_gnt(10, ok);
        slv_en = 1'b1;
        cap_en = 1'b1;
        tests++;
        if (!ok || gnt !== 4'b0100 || cs_n !== 4'b1011) begin
            fails++;
            $display("FAIL m3_grant gnt=%b cs_n=%b, required 0100/1011", gnt, cs_n);
        end
        tests++;
        if (sclk !== 1'b1 || mosi !== 1'b0) begin
            fails++;
            $display("FAIL m3_idle sclk=%b mosi=%b, required 1/0", sclk, mosi);
        end
        sb.push_back('{idx: 2, rx: 8'h96});
        req = '0;
        bad = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
            if (cs_n !== 4'b1011) bad++;
        end
        tests++;
        if (!ok || bad != 0) begin
            fails++;
            $display("FAIL m3_cs done_seen=%0d bad_cycles=%0d, required 1/0", ok, bad);
        end
        e = sb.pop_front();
        tests++;
        if (done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
            fails++;
            $display("FAIL m3_rx done=%b rx=%h, required %b/%h", done, rx_data, 4'b0001 << e.idx, e.rx);
        end
        tests++;
        if (mosi_cap !== 8'h5C || sclk !== 1'b1) begin
            fails++;
            $display("FAIL m3_mosi cap=%h sclk=%b, required 5c/1", mosi_cap, sclk);
        end
        slv_en = 1'b0;
        cap_en = 1'b0;
        loop = 1'b1;
        cpol = '0;
        cpha = '0;
    endtask

    task automatic test_round_robin;
        bit   ok;
        int   g0;
        int   c0;
        int   last_done;
        int   x;
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txd = 32'h44332211;
        g0 = gnt_bad;
        c0 = cs_bad;
        last_done = 0;
        req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            x = n % 4;
            wait_gnt(50, ok);
            tests++;
            if (!ok || gnt !== (4'b0001 << x)) begin
                fails++;
                $display("FAIL rr_order n=%0d gnt=%b, required %b", n, gnt, 4'b0001 << x);
            end
            if (n > 0) begin
                tests++;
                if (cyc - last_done != 2) begin
                    fails++;
                    $display("FAIL rr_gap n=%0d got %0d, required 2", n, cyc - last_done);
                end
            end
            sb.push_back('{idx: x, rx: txd[x*8 +: 8]});
            if (n == 4) req = '0;
            wait_done(60, ok);
            last_done = cyc;
            e = sb.pop_front();
            tests++;
            if (!ok || done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
                fails++;
                $display("FAIL rr_done n=%0d done=%b rx=%h, required %b/%h", n, done, rx_data, 4'b0001 << e.idx, e.rx);
            end
        end
        tests++;
        if (gnt_bad != g0 || cs_bad != c0) begin
            fails++;
            $display("FAIL rr_onehot gnt_bad=%0d cs_bad=%0d, required 0/0", gnt_bad - g0, cs_bad - c0);
        end
    endtask

    task automatic test_fairness;
        bit         ok;
        exp_t       e;
        logic [3:0] order [3];
        order[0] = 4'b0010;
        order[1] = 4'b1000;
        order[2] = 4'b0010;
        txd[15:8] = 8'h6B;
        txd[31:24] = 8'hD2;
        req = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(50, ok);
            tests++;
            if (!ok || gnt !== order[n]) begin
                fails++;
                $display("FAIL fair_order n=%0d gnt=%b, required %b", n, gnt, order[n]);
            end
            sb.push_back('{idx: (n == 1) ? 3 : 1, rx: (n == 1) ? 8'hD2 : 8'h6B});
            if (n == 1) req[3] = 1'b0;
            if (n == 2) req = '0;
            if (n == 0) begin
                repeat (5) @(negedge clk);
                req[3] = 1'b1;
            end
            wait_done(60, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
                fails++;
                $display("FAIL fair_done n=%0d done=%b rx=%h, required %b/%h", n, done, rx_data, 4'b0001 << e.idx, e.rx);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit   ok;
        int   t0;
        int   dcnt;
        exp_t e;
        txd[7:0] = 8'h3C;
        req = 4'b0001;
        wait_gnt(50, ok);
        tests++;
        if (!ok || gnt !== 4'b0001) begin
            fails++;
            $display("FAIL rm_grant gnt=%b, required 0001", gnt);
        end
        req = '0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (cs_n !== 4'hF || sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0) begin
            fails++;
            $display("FAIL rm_async cs_n=%b sclk=%b busy=%b mosi=%b, required 1111/0/0/0", cs_n, sclk, busy, mosi);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done != '0) dcnt++;
        end
        tests++;
        if (dcnt != 0) begin
            fails++;
            $display("FAIL rm_no_done got %0d pulses, required 0", dcnt);
        end
        txd[7:0] = 8'h81;
        req = 4'b0001;
        wait_gnt(10, ok);
        t0 = cyc;
        sb.push_back('{idx: 0, rx: 8'h81});
        req = '0;
        wait_done(60, ok);
        tests++;
        if (!ok || cyc - t0 != 34) begin
            fails++;
            $display("FAIL rm_latency got %0d, required 34", cyc - t0);
        end
        e = sb.pop_front();
        tests++;
        if (done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
            fails++;
            $display("FAIL rm_rx done=%b rx=%h, required %b/%h", done, rx_data, 4'b0001 << e.idx, e.rx);
        end
    endtask

    task automatic test_withdraw;
        bit   ok;
        int   g2;
        int   c2;
        exp_t e;
        txd[7:0] = 8'h55;
        g2 = gnt2_cnt;
        c2 = cs2_cnt;
        req = 4'b0001;
        wait_gnt(50, ok);
        tests++;
        if (!ok || gnt !== 4'b0001) begin
            fails++;
            $display("FAIL wd_grant gnt=%b, required 0001", gnt);
        end
        sb.push_back('{idx: 0, rx: 8'h55});
        req = '0;
        repeat (4) @(negedge clk);
        req[2] = 1'b1;
        repeat (10) @(negedge clk);
        req[2] = 1'b0;
        wait_done(60, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || done !== (4'b0001 << e.idx) || rx_data !== e.rx) begin
            fails++;
            $display("FAIL wd_done done=%b rx=%h, required %b/%h", done, rx_data, 4'b0001 << e.idx, e.rx);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (gnt2_cnt != g2 || cs2_cnt != c2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL wd_req2 gnt2=%0d cs2_low=%0d busy=%b, required 0/0/0", gnt2_cnt - g2, cs2_cnt - c2, busy);
        end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_round_robin;
        test_fairness;
        test_reset_mid;
        test_withdraw;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
